// File: rtl/mux4_16b_core.sv
// 4-way WIDTH-bit multiplexer with a combinational output and an optional one-cycle registered copy.
// Define MUX4_16B_OREG_EN to build the registered stage; otherwise o_q and sel_q are tied to zero.
module mux4_16b_core #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    input  logic [1:0]       sel,
    output logic [WIDTH-1:0] o,
    output logic [WIDTH-1:0] o_q,
    output logic [1:0]       sel_q
);

    logic [WIDTH-1:0] mux_s;

    // Flat 4-way select; an unknown select code drives zeros rather than propagating X.
    always_comb begin
        mux_s = {WIDTH{1'b0}};
        case (sel)
            2'd0:    mux_s = a;
            2'd1:    mux_s = b;
            2'd2:    mux_s = c;
            2'd3:    mux_s = d;
            default: mux_s = {WIDTH{1'b0}};
        endcase
    end

    assign o = mux_s;

`ifdef MUX4_16B_OREG_EN
    logic [WIDTH-1:0] o_q_r;
    logic [1:0]       sel_q_r;

    // Capture the mux output and its select together so they stay aligned; reset wins over capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_q_r   <= {WIDTH{1'b0}};
            sel_q_r <= 2'b00;
        end else begin
            o_q_r   <= mux_s;
            sel_q_r <= sel;
        end
    end

    assign o_q   = o_q_r;
    assign sel_q = sel_q_r;
`else
    // Clock and reset have no loads when the registered stage is compiled out.
    logic unused_s;
    assign unused_s = &{1'b0, clk, rst};

    assign o_q   = {WIDTH{1'b0}};
    assign sel_q = 2'b00;
`endif

endmodule

// File: tb/tb_mux4_16b_core.sv
// Directed self-checking bench for mux4_16b_core; the registered-stage checks follow MUX4_16B_OREG_EN.
module tb_mux4_16b_core;

    logic        clk;
    logic        rst;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] c;
    logic [15:0] d;
    logic [1:0]  sel;
    logic [15:0] o;
    logic [15:0] o_q;
    logic [1:0]  sel_q;

    int n_checks;
    int n_errors;

    mux4_16b_core #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst   (rst),
        .a     (a),
        .b     (b),
        .c     (c),
        .d     (d),
        .sel   (sel),
        .o     (o),
        .o_q   (o_q),
        .sel_q (sel_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (act !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        a   = 16'd1;
        b   = 16'd2;
        c   = 16'd3;
        d   = 16'd4;
        sel = 2'd0;

        // Reset state of the registered outputs
        @(posedge clk);
        #1;
        check_val("rst_o_q", {16'd0, o_q}, 32'd0);
        check_val("rst_sel_q", {30'd0, sel_q}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Step sel through every code, 5 ns apart
        sel = 2'd0; #5; check_val("sel0", {16'd0, o}, 32'd1);
        sel = 2'd1; #5; check_val("sel1", {16'd0, o}, 32'd2);
        sel = 2'd2; #5; check_val("sel2", {16'd0, o}, 32'd3);
        sel = 2'd3; #5; check_val("sel3", {16'd0, o}, 32'd4);

        // Two-bit wrap of sel back to input a
        sel = sel + 2'd1; #5;
        check_val("wrap", {16'd0, o}, 32'd1);

        // Unselected input change must not disturb o, selected change must
        sel = 2'd2; #5;
        a = 16'hFFFF; #5;
        check_val("unsel_a", {16'd0, o}, 32'd3);
        c = 16'h00AA; #5;
        check_val("sel_c", {16'd0, o}, 32'h0000_00AA);

        // Full-width patterns on every leg
        a = 16'hA5A5; b = 16'h5A5A; c = 16'h8001; d = 16'h7FFE;
        sel = 2'd0; #5; check_val("pat_a", {16'd0, o}, 32'h0000_A5A5);
        sel = 2'd1; #5; check_val("pat_b", {16'd0, o}, 32'h0000_5A5A);
        sel = 2'd2; #5; check_val("pat_c", {16'd0, o}, 32'h0000_8001);
        sel = 2'd3; #5; check_val("pat_d", {16'd0, o}, 32'h0000_7FFE);
        b = 16'h0000; #5; check_val("unsel_b", {16'd0, o}, 32'h0000_7FFE);

`ifdef MUX4_16B_OREG_EN
        // Establish a known prior value, then load b through the register
        @(negedge clk);
        sel = 2'd3; d = 16'd4;
        @(posedge clk); #1;
        check_val("prior_o_q", {16'd0, o_q}, 32'd4);
        @(negedge clk);
        sel = 2'd1; b = 16'h1234;
        #1;
        check_val("hold_o_q", {16'd0, o_q}, 32'd4);
        check_val("hold_sel_q", {30'd0, sel_q}, 32'd3);
        @(posedge clk); #1;
        check_val("cap_o_q", {16'd0, o_q}, 32'h0000_1234);
        check_val("cap_sel_q", {30'd0, sel_q}, 32'd1);

        // Reset overrides capture while o keeps following inputs
        @(negedge clk);
        sel = 2'd3; d = 16'd4; rst = 1'b1;
        #1;
        check_val("rst_o_pre", {16'd0, o}, 32'd4);
        @(posedge clk); #1;
        check_val("rst2_o_q", {16'd0, o_q}, 32'd0);
        check_val("rst2_sel_q", {30'd0, sel_q}, 32'd0);
        check_val("rst_o", {16'd0, o}, 32'd4);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check_val("resume_o_q", {16'd0, o_q}, 32'd4);
        check_val("resume_sel_q", {30'd0, sel_q}, 32'd3);
`else
        // Without the registered stage the outputs stay zero under any stimulus
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            sel = i[1:0];
            a = 16'h1111; b = 16'h2222; c = 16'h3333; d = 16'h4444;
            rst = (i == 2) ? 1'b1 : 1'b0;
            @(posedge clk); #1;
            check_val("noreg_o_q", {16'd0, o_q}, 32'd0);
            check_val("noreg_sel_q", {30'd0, sel_q}, 32'd0);
        end
        check_val("noreg_o", {16'd0, o}, 32'h0000_4444);
        rst = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
